// File: rtl/imm_pack.sv
// imm_pack: RV32I field packer, the inverse of decode-side immediate extraction.
// Two-stage valid/ready pipeline; S1 holds fields + range check, S2 the packed word.

`ifndef XLEN
`define XLEN 32
`endif

module imm_pack #(
  parameter int XLEN  = `XLEN,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [XLEN-1:0]  in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam int OH_R = 0;
  localparam int OH_I = 1;
  localparam int OH_S = 2;
  localparam int OH_B = 3;
  localparam int OH_U = 4;
  localparam int OH_J = 5;
  localparam int OH_X = 6;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [6:0]  fmt_oh;
    logic        err;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } s1_t;

  // Handshake
  logic s2_load;
  logic s1_load;
  logic fire;

  // Stage 1
  logic s1_valid_q;
  logic s1_valid_d;
  s1_t  s1_q;
  s1_t  s1_d;

  // Input-side decode and range check
  logic [6:0]      fmt_oh;
  logic            rng_err;
  logic [XLEN-1:11] run11;
  logic [XLEN-1:12] run12;
  logic [XLEN-1:20] run20;
  logic            ok11;
  logic            ok12;
  logic            ok20;

  // Stage 2
  logic        out_valid_q;
  logic        out_valid_d;
  logic [31:0] instr_q;
  logic [31:0] instr_d;
  logic        err_q;
  logic        err_d;
  logic [31:0] pack;
  logic        pack_err;

  // Counters
  logic [CNT_W-1:0] word_cnt_q;
  logic [CNT_W-1:0] word_cnt_d;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;

  assign s2_load  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;
  assign s1_load  = in_valid && in_ready;
  assign fire     = out_valid_q && out_ready;

  assign out_valid = out_valid_q;
  assign out_instr = instr_q;
  assign out_err   = err_q;
  assign word_cnt  = word_cnt_q;
  assign err_cnt   = err_cnt_q;

  // Sign-run checks: an immediate fits when every bit above
  // the format's sign bit replicates it.
  assign run11 = in_imm[XLEN-1:11];
  assign run12 = in_imm[XLEN-1:12];
  assign run20 = in_imm[XLEN-1:20];
  assign ok11  = (&run11) | ~(|run11);
  assign ok12  = (&run12) | ~(|run12);
  assign ok20  = (&run20) | ~(|run20);

  // Decode format to one-hot and flag unrepresentable immediates
  always_comb begin
    fmt_oh  = '0;
    rng_err = 1'b0;
    case (in_fmt)
      FMT_R: begin
        fmt_oh[OH_R] = 1'b1;
      end
      FMT_I: begin
        fmt_oh[OH_I] = 1'b1;
        rng_err      = !ok11;
      end
      FMT_S: begin
        fmt_oh[OH_S] = 1'b1;
        rng_err      = !ok11;
      end
      FMT_B: begin
        fmt_oh[OH_B] = 1'b1;
        rng_err      = !ok12 || in_imm[0];
      end
      FMT_U: begin
        fmt_oh[OH_U] = 1'b1;
        rng_err      = |in_imm[11:0];
      end
      FMT_J: begin
        fmt_oh[OH_J] = 1'b1;
        rng_err      = !ok20 || in_imm[0];
      end
      default: begin
        fmt_oh[OH_X] = 1'b1;
        rng_err      = 1'b1;
      end
    endcase
  end

  // S1 next state: capture request fields when accepted
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (s1_load) begin
      s1_d.fmt_oh = fmt_oh;
      s1_d.err    = rng_err;
      s1_d.opcode = in_opcode;
      s1_d.rd     = in_rd;
      s1_d.rs1    = in_rs1;
      s1_d.rs2    = in_rs2;
      s1_d.f3     = in_funct3;
      s1_d.f7     = in_funct7;
      s1_d.imm    = in_imm[31:0];
    end
  end

  // S1 registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
    end
  end

  // Pack S1 fields into the RV32I word for the held format
  always_comb begin
    pack     = NOP;
    pack_err = s1_q.err;
    unique case (1'b1)
      s1_q.fmt_oh[OH_R]: begin
        pack = {s1_q.f7, s1_q.rs2, s1_q.rs1,
                s1_q.f3, s1_q.rd, s1_q.opcode};
      end
      s1_q.fmt_oh[OH_I]: begin
        pack = {s1_q.imm[11:0], s1_q.rs1,
                s1_q.f3, s1_q.rd, s1_q.opcode};
      end
      s1_q.fmt_oh[OH_S]: begin
        pack = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1,
                s1_q.f3, s1_q.imm[4:0], s1_q.opcode};
      end
      s1_q.fmt_oh[OH_B]: begin
        pack = {s1_q.imm[12], s1_q.imm[10:5],
                s1_q.rs2, s1_q.rs1, s1_q.f3,
                s1_q.imm[4:1], s1_q.imm[11],
                s1_q.opcode};
      end
      s1_q.fmt_oh[OH_U]: begin
        pack = {s1_q.imm[31:12], s1_q.rd, s1_q.opcode};
      end
      s1_q.fmt_oh[OH_J]: begin
        pack = {s1_q.imm[20], s1_q.imm[10:1],
                s1_q.imm[11], s1_q.imm[19:12],
                s1_q.rd, s1_q.opcode};
      end
      default: begin
        pack     = NOP;
        pack_err = 1'b1;
      end
    endcase
  end

  // S2 next state: load from S1 when the output slot frees up
  always_comb begin
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    err_d       = err_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        instr_d = pack;
        err_d   = pack_err;
      end
    end
  end

  // S2 registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      err_q       <= err_d;
    end
  end

  // Saturating counters advance only on an emitted word
  always_comb begin
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (fire && !(&word_cnt_q)) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end
    if (fire && err_q && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_pack.sv
// tb_imm_pack: table vectors, directed flow-control sequences and
// random traffic against an arithmetic reference model and scoreboard.

module tb_imm_pack;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  typedef struct {
    string name;
    req_t  r;
    exp_t  e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] word_cnt;
  logic [15:0] err_cnt;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_out_instr;
  logic        s_out_err;
  logic [3:0]  s_word_cnt;
  logic [3:0]  s_err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_pack #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .word_cnt(word_cnt), .err_cnt(err_cnt)
  );

  imm_pack #(.XLEN(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_instr(s_out_instr), .out_err(s_out_err),
    .word_cnt(s_word_cnt), .err_cnt(s_err_cnt)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Reference: fields placed by shift, range judged on the signed value.
  function automatic exp_t model(req_t r);
    exp_t e;
    int s;
    bit [31:0] i, op, rd, rs1, rs2, f3, f7;
    i = r.imm;
    s = $signed(r.imm);
    op = 32'(r.op);
    rd = 32'(r.rd);
    rs1 = 32'(r.rs1);
    rs2 = 32'(r.rs2);
    f3 = 32'(r.f3);
    f7 = 32'(r.f7);
    case (r.fmt)
      3'd0: begin
        e.instr = op | rd << 7 | f3 << 12 | rs1 << 15
                | rs2 << 20 | f7 << 25;
        e.err = 1'b0;
      end
      3'd1: begin
        e.instr = op | rd << 7 | f3 << 12 | rs1 << 15
                | (i & 32'hFFF) << 20;
        e.err = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        e.instr = op | (i & 31) << 7 | f3 << 12 | rs1 << 15
                | rs2 << 20 | ((i >> 5) & 127) << 25;
        e.err = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        e.instr = op | ((i >> 11) & 1) << 7
                | ((i >> 1) & 15) << 8 | f3 << 12
                | rs1 << 15 | rs2 << 20
                | ((i >> 5) & 63) << 25
                | ((i >> 12) & 1) << 31;
        e.err = (s < -4096) || (s > 4095) || (s % 2 != 0);
      end
      3'd4: begin
        e.instr = op | rd << 7 | (i & 32'hFFFF_F000);
        e.err = (i % 4096) != 0;
      end
      3'd5: begin
        e.instr = op | rd << 7 | ((i >> 12) & 255) << 12
                | ((i >> 11) & 1) << 20
                | ((i >> 1) & 1023) << 21
                | ((i >> 20) & 1) << 31;
        e.err = (s < -1048576) || (s > 1048575) || (s % 2 != 0);
      end
      default: begin
        e.instr = 32'h0000_0013;
        e.err = 1'b1;
      end
    endcase
    return e;
  endfunction

  function automatic req_t cur_req();
    req_t r;
    r.fmt = in_fmt;
    r.op = in_opcode;
    r.rd = in_rd;
    r.rs1 = in_rs1;
    r.rs2 = in_rs2;
    r.f3 = in_funct3;
    r.f7 = in_funct7;
    r.imm = in_imm;
    return r;
  endfunction

  function automatic req_t mk(logic [2:0] fmt, logic [6:0] op,
                              logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, logic [2:0] f3,
                              logic [31:0] imm);
    req_t r;
    r.fmt = fmt;
    r.op = op;
    r.rd = rd;
    r.rs1 = rs1;
    r.rs2 = rs2;
    r.f3 = f3;
    r.f7 = 7'd0;
    r.imm = imm;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.fmt = 3'($urandom % 8);
    r.op = 7'($urandom);
    r.rd = 5'($urandom);
    r.rs1 = 5'($urandom);
    r.rs2 = 5'($urandom);
    r.f3 = 3'($urandom);
    r.f7 = 7'($urandom);
    case ($urandom % 5)
      0: r.imm = 32'($urandom_range(0, 10000)) - 32'd5000;
      1: r.imm = 32'($urandom) << 12;
      2: r.imm = 32'($urandom_range(0, 4194304)) - 32'd2097152;
      3: r.imm = (32'($urandom_range(0, 4096)) - 32'd2048) & ~32'd1;
      default: r.imm = 32'($urandom);
    endcase
    return r;
  endfunction

  task automatic set_req(req_t r, logic v);
    in_valid = v;
    in_fmt = r.fmt;
    in_opcode = r.op;
    in_rd = r.rd;
    in_rs1 = r.rs1;
    in_rs2 = r.rs2;
    in_funct3 = r.f3;
    in_funct7 = r.f7;
    in_imm = r.imm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard / counter model, sampled on the falling edge
  exp_t        sbq[$];
  int          m_words = 0;
  int          m_errs = 0;
  bit          mon_en = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_instr;
  logic        prev_err;

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("word_cnt", 32'(word_cnt), 32'(m_words));
      chk("err_cnt", 32'(err_cnt), 32'(m_errs));
      chk("sat_word_cnt", 32'(s_word_cnt),
          32'((m_words > 15) ? 15 : m_words));
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_instr", out_instr, prev_instr);
        chk("stall_err", 32'(out_err), 32'(prev_err));
      end
    end
    if (rst) begin
      sbq.delete();
      m_words = 0;
      m_errs = 0;
      prev_stall = 1'b0;
    end else if (mon_en) begin
      if (in_valid && in_ready) begin
        sbq.push_back(model(cur_req()));
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word got %h want none", out_instr);
        end else begin
          e = sbq.pop_front();
          chk("sb_instr", out_instr, e.instr);
          chk("sb_err", 32'(out_err), 32'(e.err));
          if (e.err) m_errs++;
        end
        m_words++;
      end
      prev_stall = out_valid && !out_ready;
      prev_instr = out_instr;
      prev_err = out_err;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  vec_t vt[10];
  req_t rq;
  bit   seen;
  bit   acc;
  bit   saw_block;
  int   idx;
  int   run;
  int   run_max;
  int   n;

  initial begin
    vt[0] = '{"i_addi", mk(1, 7'h13, 1, 0, 0, 0, 32'd5), '{32'h0050_0093, 1'b0}};
    vt[1] = '{"s_sw", mk(2, 7'h23, 0, 1, 2, 2, 32'd8), '{32'h0020_A423, 1'b0}};
    vt[2] = '{"b_beq", mk(3, 7'h63, 0, 0, 0, 0, 32'hFFFF_FFFC), '{32'hFE00_0EE3, 1'b0}};
    vt[3] = '{"u_lui", mk(4, 7'h37, 5, 0, 0, 0, 32'h1234_5000), '{32'h1234_52B7, 1'b0}};
    vt[4] = '{"j_jal", mk(5, 7'h6F, 1, 0, 0, 0, 32'd8), '{32'h0080_00EF, 1'b0}};
    vt[5] = '{"i_2048", mk(1, 7'h13, 1, 0, 0, 0, 32'd2048), '{32'h8000_0093, 1'b1}};
    vt[6] = '{"b_6", mk(3, 7'h63, 0, 0, 0, 0, 32'd6), '{32'h0000_0363, 1'b0}};
    vt[7] = '{"b_7", mk(3, 7'h63, 0, 0, 0, 0, 32'd7), '{32'h0000_0363, 1'b1}};
    vt[8] = '{"u_1001", mk(4, 7'h37, 5, 0, 0, 0, 32'h0000_1001), '{32'h0000_12B7, 1'b1}};
    vt[9] = '{"fmt7", mk(7, 7'h33, 3, 4, 5, 1, 32'd0), '{32'h0000_0013, 1'b1}};

    rst = 1'b1;
    out_ready = 1'b1;
    set_req(vt[0].r, 1'b0);
    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);

    // Latency: accepted at edge 1, visible after edge 2
    set_req(vt[0].r, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("lat_edge1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat_edge2_valid", 32'(out_valid), 32'd1);
    chk("lat_edge2_instr", out_instr, 32'h0050_0093);
    tick();

    // Table vectors, one at a time
    for (int v = 0; v < 10; v++) begin
      set_req(vt[v].r, 1'b1);
      tick();
      in_valid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 6 && !seen; c++) begin
        if (out_valid) seen = 1'b1;
        else tick();
      end
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout got none want word", vt[v].name);
      end else begin
        chk({vt[v].name, "_instr"}, out_instr, vt[v].e.instr);
        chk({vt[v].name, "_err"}, 32'(out_err), 32'(vt[v].e.err));
      end
      tick();
    end
    tick();
    chk("plan_err_cnt", 32'(err_cnt), 32'd4);

    // Backpressure: out_ready low during cycles 3..6
    do_reset();
    idx = 0;
    saw_block = 1'b0;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      if (idx < 5) set_req(vt[idx].r, 1'b1);
      else in_valid = 1'b0;
      @(negedge clk);
      if (in_valid && !in_ready) saw_block = 1'b1;
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    chk("bp_in_ready_dropped", 32'(saw_block), 32'd1);
    chk("bp_all_accepted", 32'(idx), 32'd5);
    chk("bp_word_cnt", 32'(word_cnt), 32'd5);

    // Throughput: 20 back-to-back words
    do_reset();
    out_ready = 1'b1;
    run = 0;
    run_max = 0;
    n = 0;
    for (int c = 0; c < 26; c++) begin
      if (c < 20) begin
        set_req(rand_req(), 1'b1);
        if (!in_ready) n++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (out_valid) run++;
      else run = 0;
      if (run > run_max) run_max = run;
    end
    chk("tp_stalls", 32'(n), 32'd0);
    chk("tp_run", 32'(run_max), 32'd20);
    chk("tp_word_cnt", 32'(word_cnt), 32'd20);

    // Reset with two words in flight
    do_reset();
    out_ready = 1'b0;
    set_req(vt[1].r, 1'b1);
    tick();
    set_req(vt[3].r, 1'b1);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_word_cnt", 32'(word_cnt), 32'd0);
    chk("mid_err_cnt", 32'(err_cnt), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    n = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (out_valid) n++;
    end
    chk("mid_no_stale", 32'(n), 32'd0);

    // Saturation of the narrow-counter instance
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      set_req(rand_req(), 1'b1);
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("sat_cnt4", 32'(s_word_cnt), 32'd15);
    chk("sat_cnt16", 32'(word_cnt), 32'd18);

    // Random traffic with random backpressure
    do_reset();
    rq = rand_req();
    for (int c = 0; c < 500; c++) begin
      out_ready = ($urandom % 3) != 0;
      set_req(rq, ($urandom % 4) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) rq = rand_req();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (sbq.size() == 0 && !out_valid) seen = 1'b1;
    end
    chk("rand_drained", 32'(seen), 32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
